// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiters.
// State encoding, width derivation and one-hot decode.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned oh2idx(
    input logic [31:0] oh
  );
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Masked round-robin pick: lowest request at or above ptr,
// falling back to the lowest request overall.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    pick,
  output logic [ID_W-1:0] idx
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] lo_m;
  logic [N-1:0] lo_u;

  // Two lowest-set-bit encoders, masked one wins when non-empty
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++)
      mask[i] = (ID_W'(i) >= ptr);
    masked = req & mask;
    lo_m   = masked & (~masked + N'(1));
    lo_u   = req & (~req + N'(1));
    pick   = (|masked) ? lo_m : lo_u;
    idx    = ID_W'(oh2idx(32'(pick)));
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold and bounded tenure.
// Owner keeps the grant while req is high, preempted at MAX_HOLD.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4,
  parameter int ID_W     = 2
) (
  input  logic            clk,
  input  logic            rst_an,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] owner,
  output logic            busy,
  output logic            preempt
);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_nxt;
  logic [ID_W-1:0]  pick_idx;
  logic [N-1:0]     pick;
  logic             own_req;
  logic             others;
  logic             at_limit;

  rr_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  // Owner request, contention, tenure limit and next pointer
  always_comb begin
    own_req  = |(req & grant);
    others   = |(req & ~grant);
    at_limit = (MAX_HOLD != 0) &&
               (hold_cnt == CNT_W'(MAX_HOLD));
    ptr_nxt  = (pick_idx == ID_W'(N - 1)) ?
               '0 : pick_idx + ID_W'(1);
  end

  // Grant FSM; every release passes through one idle cycle
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= '0;
    end else begin
      preempt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            grant    <= pick;
            owner    <= pick_idx;
            busy     <= 1'b1;
            ptr      <= ptr_nxt;
            hold_cnt <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (!own_req || (at_limit && others)) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            preempt  <= own_req;
          end else if (at_limit) begin
            hold_cnt <= CNT_W'(1);
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
